// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: default address width, address word type and the
// active-low control-strobe convention used by the bus-loaded registers.
package sap1_pkg;

    localparam int unsigned SAP1_ADDR_W = 4;

    typedef logic [SAP1_ADDR_W-1:0] addr_t;

    // Control strobes from the controller-sequencer are asserted low.
    typedef enum logic {
        CTRL_ASSERTED   = 1'b0,
        CTRL_DEASSERTED = 1'b1
    } ctrl_n_e;

endpackage

// File: rtl/memory_address_register.sv
// SAP-1 Memory Address Register: captures w_bus on an active-low load strobe
// and drives the held address to the RAM from the register output only.
module memory_address_register
    import sap1_pkg::*;
#(
    parameter int unsigned           ADDR_W     = SAP1_ADDR_W,
    parameter logic [ADDR_W-1:0]     RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lm_n,
    input  logic [ADDR_W-1:0] w_bus,
    output logic [ADDR_W-1:0] ram_addres
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Conditional operator keeps an unknown strobe visible as X on the address.
    always_comb begin
        addr_d = addr_q;
        addr_d = (lm_n == CTRL_ASSERTED) ? w_bus : addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= RESET_ADDR;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign ram_addres = addr_q;

endmodule

// File: tb/tb_memory_address_register.sv
// Scoreboard bench for the MAR: stimulus pushes the expected post-edge address,
// a monitor pops and compares after each rising edge and again mid-cycle.
module tb_memory_address_register;
    import sap1_pkg::*;

    localparam int unsigned      AW    = 4;
    localparam logic [AW-1:0]    RST_V = 4'h0;

    logic          clk;
    logic          rst;
    logic          lm_n;
    logic [AW-1:0] w_bus;
    logic [AW-1:0] ram_addres;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] model_val;
    bit            model_known = 0;
    bit            done = 0;

    memory_address_register #(
        .ADDR_W     (AW),
        .RESET_ADDR (RST_V)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lm_n       (lm_n),
        .w_bus      (w_bus),
        .ram_addres (ram_addres)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, predict, then disturb w_bus
    // shortly after the rising edge to show the output only moves on edges.
    task automatic step(input logic r, input logic l, input logic [AW-1:0] w);
        @(negedge clk);
        rst   = r;
        lm_n  = l;
        w_bus = w;
        if (r) begin
            model_val   = RST_V;
            model_known = 1;
        end else if (!l) begin
            model_val = w;
        end
        if (model_known) exp_q.push_back(model_val);
        @(posedge clk);
        #2 w_bus = AW'($urandom);
    endtask

    // Monitor: pop after each edge, then recheck the same value mid-cycle.
    initial begin
        logic [AW-1:0] held;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                held = exp_q.pop_front();
                check("post_edge", ram_addres, held);
                #3;
                check("mid_cycle_hold", ram_addres, held);
            end
        end
    end

    initial begin
        rst   = 1'b0;
        lm_n  = 1'b1;
        w_bus = '0;

        step(1'b1, 1'b0, 4'hA);                       // reset beats load
        repeat (3) step(1'b0, 1'b1, 4'h0);            // idle hold
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h4);
        step(1'b0, 1'b0, 4'hA);
        step(1'b0, 1'b0, 4'hF);
        repeat (3) step(1'b0, 1'b1, 4'hA);            // hold on deassert
        step(1'b0, 1'b0, 4'hF);
        step(1'b1, 1'b1, 4'h0);                       // mid-operation reset
        step(1'b0, 1'b0, 4'h3);
        step(1'b0, 1'b1, 4'h9);
        for (int unsigned v = 0; v < (1 << AW); v++) begin
            step(1'b0, 1'b0, AW'(v));                 // full range, back-to-back
        end
        for (int unsigned i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom), AW'($urandom));
        end
        step(1'b0, 1'b1, 4'h0);
        repeat (2) @(posedge clk);
        #6;
        done = 1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
